// File: rtl/rt_port_arbiter_pkg.sv
// Shared types and constants for the router output-port arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rt_port_arbiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } arb_state_e;

   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_S = 2;
   localparam int PORT_E = 3;
   localparam int PORT_W = 4;

   localparam int HDR_W = 4;

   // Next index in round-robin order, wrapping at n without a modulo.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rt_port_arbiter_if.sv
// Toggle-handshake bundle between the input ports, the arbiter and the downstream link.
// Latency: n/a (wiring only).
// Backpressure: a request stays pending while req != ack; data is held until acknowledged.
interface rt_port_arbiter_if #(
   parameter int N      = 32,
   parameter int NUM_IN = 5
);
   logic [NUM_IN-1:0]         in_req;
   logic [NUM_IN-1:0]         in_ack;
   logic [NUM_IN-1:0][N-1:0]  in_data;
   logic                      out_req;
   logic                      out_ack;
   logic [N-1:0]              out_data;

   // Arbiter side.
   modport slave (
      input  in_req, in_data, out_ack,
      output in_ack, out_req, out_data
   );

   // Requesters plus downstream side.
   modport master (
      output in_req, in_data, out_ack,
      input  in_ack, out_req, out_data
   );
endinterface

// File: rtl/rt_rr_pick.sv
// Combinational round-robin search: first pending index after rr_ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found is low when nothing is pending.
module rt_rr_pick
   import rt_port_arbiter_pkg::*;
#(
   parameter int NUM_IN = 5,
   parameter int IDX_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] pend,
   input  logic [IDX_W-1:0]  rr_ptr,
   output logic [IDX_W-1:0]  g,
   output logic              found
);

   // Walk rr_ptr+1, rr_ptr+2, ... and keep the first pending hit.
   always_comb begin
      int c;
      c     = int'(rr_ptr);
      g     = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         c = rr_next(c, NUM_IN);
         if (!found && pend[c]) begin
            found = 1'b1;
            g     = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/rt_port_arbiter.sv
// Round-robin output-port arbiter sharing one toggle-handshake link among NUM_IN inputs.
// Latency: pending req -> out_req toggle 1 edge; out_ack match -> in_ack toggle 1 edge (+2 each with RT_ARB_SYNC_EN).
// Backpressure: one packet in flight; out_data/out_req held until out_ack matches out_req.
module rt_port_arbiter
   import rt_port_arbiter_pkg::*;
#(
   parameter int N      = 32,
   parameter int NUM_IN = 5,
   parameter int IDX_W  = $clog2(NUM_IN)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rt_port_arbiter_if.slave     bus,
   output logic                 busy,
   output logic [IDX_W-1:0]     grant_idx
);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [NUM_IN-1:0]   in_ack_q, in_ack_d;
   logic                out_req_q, out_req_d;
   logic [N-1:0]        out_data_q, out_data_d;

   logic [NUM_IN-1:0]   req_eff;
   logic                ack_eff;
   logic [NUM_IN-1:0]   pend;
   logic [IDX_W-1:0]    pick_g;
   logic                pick_found;
   logic                ack_match;
   logic                take;
   logic                release_xfer;

`ifdef RT_ARB_SYNC_EN
   logic [NUM_IN-1:0]   req_s1_q, req_s1_d, req_s2_q, req_s2_d;
   logic                ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;

   // Synchroniser shift: each stage just samples the one before it.
   always_comb begin
      req_s1_d = bus.in_req;
      req_s2_d = req_s1_q;
      ack_s1_d = bus.out_ack;
      ack_s2_d = ack_s1_q;
   end

   // Two-flop synchronisers for links that may come from another clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_s1_q <= '0;
         req_s2_q <= '0;
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
      end else begin
         req_s1_q <= req_s1_d;
         req_s2_q <= req_s2_d;
         ack_s1_q <= ack_s1_d;
         ack_s2_q <= ack_s2_d;
      end
   end

   assign req_eff = req_s2_q;
   assign ack_eff = ack_s2_q;
`else
   assign req_eff = bus.in_req;
   assign ack_eff = bus.out_ack;
`endif

   // Pending uses the registered in_ack, so an input acked this edge is not seen again.
   assign pend      = req_eff ^ in_ack_q;
   assign ack_match = (ack_eff == out_req_q);

   rt_rr_pick #(
      .NUM_IN (NUM_IN),
      .IDX_W  (IDX_W)
   ) u_pick (
      .pend   (pend),
      .rr_ptr (rr_ptr_q),
      .g      (pick_g),
      .found  (pick_found)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: grant when anything is pending, release on matching ack.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = SEND;
         SEND:    if (ack_match)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and datapath strobes; a stray out_ack in IDLE is simply ignored.
   always_comb begin
      busy         = (state_q == SEND);
      take         = (state_q == IDLE) && pick_found;
      release_xfer = (state_q == SEND) && ack_match;
   end

   // Datapath next values: capture flit on grant, toggle the winner's ack on release.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      in_ack_d   = in_ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      if (take) begin
         out_data_d = bus.in_data[pick_g];
         out_req_d  = ~out_req_q;
         grant_d    = pick_g;
      end
      if (release_xfer) begin
         in_ack_d[grant_q] = ~in_ack_q[grant_q];
         rr_ptr_d          = grant_q;
      end
   end

   // Datapath registers; rr_ptr starts at the last index so input 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= IDX_W'(NUM_IN - 1);
         grant_q    <= IDX_W'(NUM_IN - 1);
         in_ack_q   <= '0;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         in_ack_q   <= in_ack_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
      end
   end

   assign bus.in_ack   = in_ack_q;
   assign bus.out_req  = out_req_q;
   assign bus.out_data = out_data_q;
   assign grant_idx    = grant_q;

endmodule

// File: tb/tb_rt_port_arbiter.sv
// Bench for rt_port_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: expectations follow the 1-edge (or 3-edge with RT_ARB_SYNC_EN) grant/release rules.
// Backpressure: downstream responder acks after a random 0..ds_max cycle delay.
module tb_rt_port_arbiter;
   import rt_port_arbiter_pkg::*;

   localparam int N      = 32;
   localparam int NUM_IN = 5;
   localparam int IDX_W  = $clog2(NUM_IN);
`ifdef RT_ARB_SYNC_EN
   localparam int LAT = 3;
   localparam int SP  = 4;
`else
   localparam int LAT = 1;
   localparam int SP  = 2;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             busy;
   logic [IDX_W-1:0] grant_idx;

   rt_port_arbiter_if #(.N(N), .NUM_IN(NUM_IN)) bus();

   rt_port_arbiter #(.N(N), .NUM_IN(NUM_IN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .grant_idx (grant_idx)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (transaction level) ----------------
   logic [NUM_IN-1:0] m_ack;
   logic              m_busy;
   logic              m_oreq;
   logic [N-1:0]      m_odata;
   int                m_g, m_rr;
   int                glog[$];
   int                gtime[$];
   int                cyc = 0;
   int                wait_cnt[NUM_IN];
   int                max_wait = 0;
   logic [NUM_IN-1:0] m_rq1, m_rq2;
   logic              m_ak1, m_ak2;

   // Model: at each edge either hand the link to the next pending input in circular
   // order after the last winner, or finish the current packet once downstream matches.
   always @(posedge clk or negedge rst_n) begin
      logic [NUM_IN-1:0] rq;
      logic              ak;
      logic [NUM_IN-1:0] pend;
      int                g;
      if (!rst_n) begin
         m_ack = '0; m_busy = 0; m_oreq = 0; m_odata = '0;
         m_g = NUM_IN - 1; m_rr = NUM_IN - 1;
         m_rq1 = '0; m_rq2 = '0; m_ak1 = 0; m_ak2 = 0;
         for (int i = 0; i < NUM_IN; i++) wait_cnt[i] = 0;
      end else begin
         cyc++;
`ifdef RT_ARB_SYNC_EN
         rq = m_rq2; ak = m_ak2;
         m_rq2 = m_rq1; m_rq1 = bus.in_req;
         m_ak2 = m_ak1; m_ak1 = bus.out_ack;
`else
         rq = bus.in_req; ak = bus.out_ack;
`endif
         pend = rq ^ m_ack;
         if (!m_busy) begin
            if (pend != '0) begin
               g = -1;
               for (int k = 1; k <= NUM_IN; k++)
                  if (g < 0 && pend[(m_rr + k) % NUM_IN]) g = (m_rr + k) % NUM_IN;
               for (int i = 0; i < NUM_IN; i++) begin
                  if (i != g && pend[i]) begin
                     wait_cnt[i]++;
                     if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                  end else begin
                     wait_cnt[i] = 0;
                  end
               end
               m_g = g; m_odata = bus.in_data[g]; m_oreq = ~m_oreq; m_busy = 1;
               glog.push_back(g); gtime.push_back(cyc);
            end
         end else if (ak == m_oreq) begin
            m_ack[m_g] = ~m_ack[m_g];
            m_rr = m_g;
            m_busy = 0;
         end
      end
   end

   // ---------------- stimulus and checking ----------------
   int   errors = 0;
   int   checks = 0;
   bit   ds_en, rq_en;
   int   ds_max, ds_cnt;
   int   base;
   int   sent[NUM_IN];
   logic [N-1:0] hold_dat;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: compare DUT to model on the falling edge, then run responder/requesters.
   task automatic step();
      @(negedge clk);
      if (rst_n) begin
         checks++;
         if ({bus.in_ack, bus.out_req, bus.out_data, busy, grant_idx} !==
             {m_ack, m_oreq, m_odata, m_busy, IDX_W'(m_g)}) begin
            errors++;
            $display("FAIL cycle %0d: in_ack=%b/%b out_req=%b/%b out_data=%h/%h busy=%b/%b grant=%0d/%0d (got/expected)",
                     cyc, bus.in_ack, m_ack, bus.out_req, m_oreq, bus.out_data, m_odata,
                     busy, m_busy, grant_idx, m_g);
         end
      end
      if (ds_en && bus.out_req != bus.out_ack) begin
         if (ds_cnt == 0) begin
            bus.out_ack = bus.out_req;
            ds_cnt = int'($urandom_range(ds_max, 0));
         end else begin
            ds_cnt--;
         end
      end
      if (rq_en) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (bus.in_req[i] == bus.in_ack[i] && $urandom_range(3, 0) == 0) begin
               bus.in_data[i] = $urandom;
               bus.in_req[i]  = ~bus.in_req[i];
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.in_req = '0; bus.out_ack = 1'b0; bus.in_data = '0;
      ds_en = 0; rq_en = 0; ds_max = 0; ds_cnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int glog_at(input int idx);
      return (idx < glog.size()) ? glog[idx] : -1;
   endfunction

   initial begin
      do_reset();

      // Reset values
      chk("rst_in_ack",  64'(bus.in_ack), 0);
      chk("rst_out_req", 64'(bus.out_req), 0);
      chk("rst_out_dat", 64'(bus.out_data), 0);
      chk("rst_busy",    64'(busy), 0);
      chk("rst_grant",   64'(grant_idx), NUM_IN - 1);

      // Single request on input 2
      bus.in_data[2] = 32'hA000_0012;
      bus.in_req[2]  = 1'b1;
      repeat (LAT - 1) step();
      chk("t1_early_req", 64'(bus.out_req), 0);
      step();
      chk("t1_out_req",  64'(bus.out_req), 1);
      chk("t1_out_dat",  64'(bus.out_data), 64'h0000_0000_A000_0012);
      chk("t1_grant",    64'(grant_idx), 2);
      chk("t1_busy",     64'(busy), 1);
      bus.out_ack = 1'b1;
      repeat (LAT) step();
      chk("t1_in_ack",   64'(bus.in_ack), 5'b00100);
      chk("t1_idle",     64'(busy), 0);

      // All five at once with immediate ack: strict 0..4 order, fixed spacing
      do_reset();
      ds_en = 1;
      for (int i = 0; i < NUM_IN; i++) bus.in_data[i] = 32'hB000_0000 + i;
      base = glog.size();
      bus.in_req = '1;
      repeat (40) step();
      for (int i = 0; i < NUM_IN; i++) chk("t2_order", 64'(glog_at(base + i)), i);
      for (int i = 1; i < NUM_IN; i++)
         chk("t2_spacing", 64'((base + i < gtime.size()) ? gtime[base + i] - gtime[base + i - 1] : -1), SP);
      chk("t2_in_ack", 64'(bus.in_ack), 5'b11111);

      // Inputs 1 and 3 re-request right after each ack: 1,3,1,3
      do_reset();
      ds_en = 1;
      sent[1] = 0; sent[3] = 0;
      base = glog.size();
      repeat (60) begin
         for (int i = 1; i <= 3; i += 2) begin
            if (bus.in_req[i] == bus.in_ack[i] && sent[i] < 2) begin
               bus.in_data[i] = 32'hC100_0000 + 32'(i * 16 + sent[i]);
               bus.in_req[i]  = ~bus.in_req[i];
               sent[i]++;
            end
         end
         step();
      end
      chk("t3_g0", 64'(glog_at(base + 0)), 1);
      chk("t3_g1", 64'(glog_at(base + 1)), 3);
      chk("t3_g2", 64'(glog_at(base + 2)), 1);
      chk("t3_g3", 64'(glog_at(base + 3)), 3);
      chk("t3_count", 64'(glog.size() - base), 4);

      // Downstream stalls 10 cycles: output held, no ack
      do_reset();
      hold_dat = 32'h5A5A_0003;
      bus.in_data[0] = hold_dat;
      bus.in_req[0]  = 1'b1;
      repeat (LAT) step();
      for (int c = 0; c < 10; c++) begin
         step();
         chk("t4_hold", {bus.in_ack, bus.out_req, bus.out_data, busy},
             {5'b00000, 1'b1, hold_dat, 1'b1});
      end
      ds_en = 1;
      repeat (LAT + 2) step();
      chk("t4_release", 64'(bus.in_ack), 5'b00001);

      // Reset asserted mid-transfer, between clock edges
      ds_en = 0;
      bus.in_data[3] = 32'hC0DE_0033;
      bus.in_req[3]  = 1'b1;
      repeat (LAT) step();
      chk("t5_busy_before", 64'(busy), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_in_ack",  64'(bus.in_ack), 0);
      chk("t5_out_req", 64'(bus.out_req), 0);
      chk("t5_out_dat", 64'(bus.out_data), 0);
      chk("t5_busy",    64'(busy), 0);
      chk("t5_grant",   64'(grant_idx), NUM_IN - 1);
      bus.in_req = '0; bus.out_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_data[4] = 32'h4444_0004;
      bus.in_req[4]  = 1'b1;
      repeat (LAT) step();
      chk("t5_grant4", 64'(grant_idx), 4);
      chk("t5_busy4",  64'(busy), 1);
      chk("t5_dat4",   64'(bus.out_data), 64'h0000_0000_4444_0004);

      // Stray out_ack toggle while idle: ignored, next grant still issued
      do_reset();
      bus.out_ack = 1'b1;
      repeat (4) step();
      chk("t6_idle_busy", 64'(busy), 0);
      chk("t6_idle_req",  64'(bus.out_req), 0);
      bus.in_data[2] = 32'hD000_0002;
      bus.in_req[2]  = 1'b1;
      repeat (LAT) step();
      chk("t6_grant", {busy, bus.out_req, grant_idx}, {1'b1, 1'b1, IDX_W'(2)});
      repeat (LAT + 1) step();
      chk("t6_done", {busy, bus.in_ack}, {1'b0, 5'b00100});

      // Randomized traffic with random downstream delay
      do_reset();
      ds_en = 1; rq_en = 1; ds_max = 3;
      base = glog.size();
      repeat (3000) step();
      rq_en = 0;
      repeat (60) step();
      chk("rand_fair", 64'(max_wait > NUM_IN - 1), 0);
      chk("rand_activity", 64'(glog.size() - base > 200), 1);
      chk("rand_drained", 64'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
